// File: rtl/emc_mch_pkg.sv
// Shared types and helpers for the multi-channel external memory controller.
package emc_mch_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_STRB  = 2'd1,
        ST_XWAIT = 2'd2,
        ST_END   = 2'd3
    } state_e;

    function automatic int tmo_w(input int tmo);
        return $clog2(tmo);
    endfunction

    // LSB position of channel ch's field inside a packed per-channel bus.
    function automatic int fld_lo(input int ch, input int w);
        return ch * w;
    endfunction

endpackage

// File: rtl/emc_mch_rr.sv
// Channel arbiter: fixed priority (ch0 first) or round-robin from a rotating pointer.
module emc_rr_arb #(
    parameter int NCH = 4,
    parameter int ARB = 1
) (
    input  logic           DSPCLK,
    input  logic           PPclr,
    input  logic [NCH-1:0] req,
    input  logic           adv,
    output logic [NCH-1:0] gnt,
    output logic           valid
);
    localparam int PW = (NCH > 1) ? $clog2(NCH) : 1;

    logic [PW-1:0] ptr_q, ptr_d;
    int            gidx;
    int            idx;

    // Search starts at the pointer, so the channel just served is tried last.
    always_comb begin
        gnt   = '0;
        valid = 1'b0;
        gidx  = 0;
        idx   = 0;
        for (int i = 0; i < NCH; i++) begin
            idx = (ARB != 0) ? (int'(ptr_q) + i) % NCH : i;
            for (int j = 0; j < NCH; j++) begin
                if (!valid && j == idx && req[j]) begin
                    gnt[j] = 1'b1;
                    valid  = 1'b1;
                    gidx   = j;
                end
            end
        end
    end

    always_comb begin
        ptr_d = ptr_q;
        if (adv) ptr_d = PW'((gidx + 1) % NCH);
    end

    always_ff @(posedge DSPCLK or posedge PPclr) begin
        if (PPclr) ptr_q <= '0;
        else       ptr_q <= ptr_d;
    end

endmodule

// File: rtl/emc_mch.sv
// Multi-channel external memory controller: arbitration, wait states, ready extension
// with timeout, all pin outputs registered.
module emc_mch
    import emc_mch_pkg::*;
#(
    parameter int NCH = 4,
    parameter int AW  = 15,
    parameter int DW  = 16,
    parameter int WW  = 6,
    parameter int ARB = 1,
    parameter int TMO = 64
) (
    input  logic              DSPCLK,
    input  logic              PPclr,
    input  logic [NCH-1:0]    req,
    input  logic [NCH-1:0]    we,
    input  logic [NCH*AW-1:0] addr,
    input  logic [NCH*DW-1:0] wdata,
    input  logic [NCH*WW-1:0] wait_cfg,
    input  logic              BGn,
    input  logic              XRDY,
    input  logic [DW-1:0]     ED_in,
    output logic [NCH-1:0]    ack,
    output logic [NCH-1:0]    err,
    output logic [DW-1:0]     rdata,
    output logic [NCH-1:0]    CSn,
    output logic              RDn,
    output logic              WRn,
    output logic [AW-1:0]     EA_do,
    output logic              EA_oe,
    output logic [DW-1:0]     ED_do,
    output logic              ED_oe,
    output logic              busy
);
    localparam int TW = tmo_w(TMO);

    state_e         state_q, state_d;
    logic [NCH-1:0] gnt, g_q, g_d, csn_q, csn_d, ack_q, ack_d, err_q, err_d;
    logic           valid, adv, tmo_hit, we_q, we_d, sel_we, strobe, active;
    logic [AW-1:0]  addr_q, addr_d, sel_addr, ea_do_q, ea_do_d;
    logic [DW-1:0]  wdata_q, wdata_d, sel_wdata, ed_do_q, ed_do_d, rdata_q, rdata_d;
    logic [WW-1:0]  wait_q, wait_d, sel_wait, cnt_q, cnt_d;
    logic [TW-1:0]  tcnt_q, tcnt_d;
    logic           rdn_q, rdn_d, wrn_q, wrn_d, ea_oe_q, ea_oe_d, ed_oe_q, ed_oe_d;
    logic           busy_q, busy_d;

    emc_rr_arb #(.NCH(NCH), .ARB(ARB)) u_arb (
        .DSPCLK (DSPCLK),
        .PPclr  (PPclr),
        .req    (req),
        .adv    (adv),
        .gnt    (gnt),
        .valid  (valid)
    );

    always_comb begin
        sel_we    = 1'b0;
        sel_addr  = '0;
        sel_wdata = '0;
        sel_wait  = '0;
        for (int j = 0; j < NCH; j++) begin
            if (gnt[j]) begin
                sel_we    = we[j];
                sel_addr  = addr[fld_lo(j, AW) +: AW];
                sel_wdata = wdata[fld_lo(j, DW) +: DW];
                sel_wait  = wait_cfg[fld_lo(j, WW) +: WW];
            end
        end
    end

    always_comb begin
        state_d = state_q;
        g_d     = g_q;
        we_d    = we_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        wait_d  = wait_q;
        cnt_d   = cnt_q;
        tcnt_d  = tcnt_q;
        rdata_d = rdata_q;
        adv     = 1'b0;
        tmo_hit = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (BGn && valid) begin
                    adv     = 1'b1;
                    g_d     = gnt;
                    we_d    = sel_we;
                    addr_d  = sel_addr;
                    wdata_d = sel_wdata;
                    wait_d  = sel_wait;
                    cnt_d   = '0;
                    state_d = ST_STRB;
                end
            end
            ST_STRB: begin
                // Equality test before increment keeps the counter from wrapping.
                if (cnt_q == wait_q) begin
                    if (XRDY) begin
                        state_d = ST_END;
                    end else begin
                        state_d = ST_XWAIT;
                        tcnt_d  = '0;
                    end
                end else begin
                    cnt_d = cnt_q + WW'(1);
                end
            end
            ST_XWAIT: begin
                if (XRDY) begin
                    state_d = ST_END;
                end else if (tcnt_q == TW'(TMO - 1)) begin
                    state_d = ST_END;
                    tmo_hit = 1'b1;
                end else begin
                    tcnt_d = tcnt_q + TW'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (state_d == ST_END && !we_q && !tmo_hit) rdata_d = ED_in;

        // Pins are registered from the next state so they line up with it.
        strobe  = (state_d == ST_STRB) || (state_d == ST_XWAIT);
        active  = strobe || (state_d == ST_END);
        csn_d   = active ? ~g_d : '1;
        rdn_d   = !(strobe && !we_d);
        wrn_d   = !(strobe && we_d);
        ea_oe_d = active;
        ea_do_d = active ? addr_d : ea_do_q;
        ed_oe_d = active && we_d;
        ed_do_d = (active && we_d) ? wdata_d : ed_do_q;
        ack_d   = (state_d == ST_END && !tmo_hit) ? g_d : '0;
        err_d   = (state_d == ST_END && tmo_hit) ? g_d : '0;
        busy_d  = (state_d != ST_IDLE);
    end

    always_ff @(posedge DSPCLK or posedge PPclr) begin
        if (PPclr) begin
            state_q <= ST_IDLE;
            g_q     <= '0;
            we_q    <= 1'b0;
            cnt_q   <= '0;
            tcnt_q  <= '0;
            csn_q   <= '1;
            rdn_q   <= 1'b1;
            wrn_q   <= 1'b1;
            ea_oe_q <= 1'b0;
            ed_oe_q <= 1'b0;
            ea_do_q <= '0;
            ed_do_q <= '0;
            rdata_q <= '0;
            ack_q   <= '0;
            err_q   <= '0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            g_q     <= g_d;
            we_q    <= we_d;
            cnt_q   <= cnt_d;
            tcnt_q  <= tcnt_d;
            csn_q   <= csn_d;
            rdn_q   <= rdn_d;
            wrn_q   <= wrn_d;
            ea_oe_q <= ea_oe_d;
            ed_oe_q <= ed_oe_d;
            ea_do_q <= ea_do_d;
            ed_do_q <= ed_do_d;
            rdata_q <= rdata_d;
            ack_q   <= ack_d;
            err_q   <= err_d;
            busy_q  <= busy_d;
        end
    end

    always_ff @(posedge DSPCLK) begin
        addr_q  <= addr_d;
        wdata_q <= wdata_d;
        wait_q  <= wait_d;
    end

    assign ack   = ack_q;
    assign err   = err_q;
    assign rdata = rdata_q;
    assign CSn   = csn_q;
    assign RDn   = rdn_q;
    assign WRn   = wrn_q;
    assign EA_do = ea_do_q;
    assign EA_oe = ea_oe_q;
    assign ED_do = ed_do_q;
    assign ED_oe = ed_oe_q;
    assign busy  = busy_q;

endmodule

// File: tb/tb_emc_mch.sv
// Scoreboard bench for emc_mch: a round-robin instance and a fixed-priority twin share stimulus.
module tb_emc_mch;
    localparam int NCH = 4, AW = 15, DW = 16, WW = 6, TMO = 8;

    logic              clk = 1'b0;
    logic              PPclr;
    logic [NCH-1:0]    req, we;
    logic [NCH*AW-1:0] addr;
    logic [NCH*DW-1:0] wdata;
    logic [NCH*WW-1:0] wait_cfg;
    logic              BGn, XRDY;
    logic [DW-1:0]     ED_in;

    logic [NCH-1:0] ack, err, CSn;
    logic [DW-1:0]  rdata, ED_do;
    logic [AW-1:0]  EA_do;
    logic           RDn, WRn, EA_oe, ED_oe, busy;

    logic [NCH-1:0] ack2, err2, csn2;
    logic [DW-1:0]  rdata2, ed_do2;
    logic [AW-1:0]  ea_do2;
    logic           rdn2, wrn2, ea_oe2, ed_oe2, busy2;

    typedef struct {
        logic [NCH-1:0] ack;
        logic [NCH-1:0] err;
        logic [DW-1:0]  rd;
        int             lat;
    } exp_t;

    exp_t sbq[$];
    int errors = 0;
    int checks = 0;
    logic [DW-1:0] rdata_model;

    int             obs_c, obs_rdl, obs_wrl, obs_edoe;
    bit             obs_ok;
    logic [NCH-1:0] obs_ack, obs_err, obs_csn0;
    logic [AW-1:0]  obs_ea0;
    logic [DW-1:0]  obs_ed0, obs_rd;

    always #5 clk = ~clk;

    emc_mch #(.NCH(NCH), .AW(AW), .DW(DW), .WW(WW), .ARB(1), .TMO(TMO)) dut (
        .DSPCLK(clk), .PPclr(PPclr), .req(req), .we(we), .addr(addr), .wdata(wdata),
        .wait_cfg(wait_cfg), .BGn(BGn), .XRDY(XRDY), .ED_in(ED_in), .ack(ack), .err(err),
        .rdata(rdata), .CSn(CSn), .RDn(RDn), .WRn(WRn), .EA_do(EA_do), .EA_oe(EA_oe),
        .ED_do(ED_do), .ED_oe(ED_oe), .busy(busy)
    );

    emc_mch #(.NCH(NCH), .AW(AW), .DW(DW), .WW(WW), .ARB(0), .TMO(TMO)) dut_fix (
        .DSPCLK(clk), .PPclr(PPclr), .req(req), .we(we), .addr(addr), .wdata(wdata),
        .wait_cfg(wait_cfg), .BGn(BGn), .XRDY(XRDY), .ED_in(ED_in), .ack(ack2), .err(err2),
        .rdata(rdata2), .CSn(csn2), .RDn(rdn2), .WRn(wrn2), .EA_do(ea_do2), .EA_oe(ea_oe2),
        .ED_do(ed_do2), .ED_oe(ed_oe2), .busy(busy2)
    );

    // Raise one channel's request and queue the completion it should produce.
    task automatic issue(input int ch, input bit w, input logic [AW-1:0] a,
                         input logic [DW-1:0] d, input logic [WW-1:0] ws, input exp_t e);
        @(posedge clk); #1;
        we[ch] = w;
        addr[ch*AW +: AW] = a;
        wdata[ch*DW +: DW] = d;
        wait_cfg[ch*WW +: WW] = ws;
        req[ch] = 1'b1;
        sbq.push_back(e);
    endtask

    // Observe pins from the sampling edge until ack/err; c counts edges after that edge.
    task automatic wait_done(input int budget, input int bg_drop);
        obs_ok = 0; obs_c = -1; obs_rdl = 0; obs_wrl = 0; obs_edoe = 0;
        obs_ack = '0; obs_err = '0;
        @(posedge clk);
        for (int c = 0; c < budget && !obs_ok; c++) begin
            @(negedge clk);
            if (c == bg_drop) BGn = 1'b0;
            if (c == 0) begin obs_csn0 = CSn; obs_ea0 = EA_do; obs_ed0 = ED_do; end
            if (!RDn) obs_rdl++;
            if (!WRn) obs_wrl++;
            if (ED_oe) obs_edoe++;
            if (|ack || |err) begin
                obs_ack = ack; obs_err = err; obs_rd = rdata; obs_c = c; obs_ok = 1;
                req = '0;
            end
        end
    endtask

    task automatic test_reset();
        PPclr = 1'b1;
        repeat (2) @(negedge clk);
        checks++; if ({CSn, RDn, WRn} !== 6'h3F) begin errors++; $display("FAIL reset_strobes got=%h want=3f", {CSn, RDn, WRn}); end
        checks++; if ({EA_oe, ED_oe, busy, ack, err} !== 11'h0) begin errors++; $display("FAIL reset_ctrl got=%h want=0", {EA_oe, ED_oe, busy, ack, err}); end
        checks++; if ({EA_do, ED_do, rdata} !== 47'h0) begin errors++; $display("FAIL reset_data got=%h want=0", {EA_do, ED_do, rdata}); end
        @(posedge clk); #1 PPclr = 1'b0;
    endtask

    task automatic test_read();
        exp_t e;
        ED_in = 16'hA5C3;
        rdata_model = 16'hA5C3;
        issue(1, 1'b0, 15'h0055, 16'h0, 6'd3, '{ack: 4'b0010, err: 4'b0, rd: rdata_model, lat: 4});
        wait_done(40, -1);
        checks++; if (!obs_ok || sbq.size() == 0) begin errors++; $display("FAIL rd_done got=%0d want=1", obs_ok); end
        else begin
            e = sbq.pop_front();
            checks++; if (obs_ack !== e.ack) begin errors++; $display("FAIL rd_ack got=%b want=%b", obs_ack, e.ack); end
            checks++; if (obs_err !== e.err) begin errors++; $display("FAIL rd_err got=%b want=%b", obs_err, e.err); end
            checks++; if (obs_c !== e.lat) begin errors++; $display("FAIL rd_lat got=%0d want=%0d", obs_c, e.lat); end
            checks++; if (obs_rd !== e.rd) begin errors++; $display("FAIL rd_data got=%h want=%h", obs_rd, e.rd); end
        end
        checks++; if (obs_rdl !== 4) begin errors++; $display("FAIL rd_strobe_len got=%0d want=4", obs_rdl); end
        checks++; if (obs_csn0 !== 4'b1101) begin errors++; $display("FAIL rd_csn got=%b want=1101", obs_csn0); end
    endtask

    task automatic test_write();
        exp_t e;
        issue(2, 1'b1, 15'h1234, 16'hBEEF, 6'd0, '{ack: 4'b0100, err: 4'b0, rd: rdata_model, lat: 1});
        wait_done(40, -1);
        checks++; if (!obs_ok || sbq.size() == 0) begin errors++; $display("FAIL wr_done got=%0d want=1", obs_ok); end
        else begin
            e = sbq.pop_front();
            checks++; if (obs_ack !== e.ack) begin errors++; $display("FAIL wr_ack got=%b want=%b", obs_ack, e.ack); end
            checks++; if (obs_c !== e.lat) begin errors++; $display("FAIL wr_lat got=%0d want=%0d", obs_c, e.lat); end
            checks++; if (obs_rd !== e.rd) begin errors++; $display("FAIL wr_rdata_kept got=%h want=%h", obs_rd, e.rd); end
        end
        checks++; if (obs_wrl !== 1 || obs_rdl !== 0) begin errors++; $display("FAIL wr_strobes got=%0d/%0d want=1/0", obs_wrl, obs_rdl); end
        checks++; if (obs_edoe !== 2) begin errors++; $display("FAIL wr_ed_oe got=%0d want=2", obs_edoe); end
        checks++; if (obs_ea0 !== 15'h1234) begin errors++; $display("FAIL wr_addr got=%h want=1234", obs_ea0); end
        checks++; if (obs_ed0 !== 16'hBEEF) begin errors++; $display("FAIL wr_data got=%h want=beef", obs_ed0); end
        checks++; if (obs_csn0 !== 4'b1011) begin errors++; $display("FAIL wr_csn got=%b want=1011", obs_csn0); end
    endtask

    task automatic test_timeout();
        exp_t e;
        XRDY = 1'b0;
        ED_in = 16'h1111;
        issue(3, 1'b0, 15'h0777, 16'h0, 6'd2, '{ack: 4'b0, err: 4'b1000, rd: rdata_model, lat: 2 + TMO + 1});
        wait_done(60, -1);
        XRDY = 1'b1;
        checks++; if (!obs_ok || sbq.size() == 0) begin errors++; $display("FAIL tmo_done got=%0d want=1", obs_ok); end
        else begin
            e = sbq.pop_front();
            checks++; if ({obs_ack, obs_err} !== {e.ack, e.err}) begin errors++; $display("FAIL tmo_pulse got=%b_%b want=%b_%b", obs_ack, obs_err, e.ack, e.err); end
            checks++; if (obs_c !== e.lat) begin errors++; $display("FAIL tmo_lat got=%0d want=%0d", obs_c, e.lat); end
            checks++; if (obs_rd !== e.rd) begin errors++; $display("FAIL tmo_rdata got=%h want=%h", obs_rd, e.rd); end
        end
        checks++; if (obs_rdl !== 3 + TMO) begin errors++; $display("FAIL tmo_strobe_len got=%0d want=%0d", obs_rdl, 3 + TMO); end
    endtask

    task automatic test_bus_grant();
        exp_t e;
        int bad;
        bad = 0;
        BGn = 1'b0;
        ED_in = 16'h0F0F;
        rdata_model = 16'h0F0F;
        issue(0, 1'b0, 15'h0042, 16'h0, 6'd1, '{ack: 4'b0001, err: 4'b0, rd: rdata_model, lat: 2});
        repeat (5) begin
            @(negedge clk);
            if (busy || EA_oe || ED_oe || CSn != 4'hF) bad++;
        end
        checks++; if (bad !== 0) begin errors++; $display("FAIL bg_blocked got=%0d want=0", bad); end
        @(posedge clk); #1 BGn = 1'b1;
        wait_done(40, 0);
        BGn = 1'b1;
        checks++; if (!obs_ok || sbq.size() == 0) begin errors++; $display("FAIL bg_done got=%0d want=1", obs_ok); end
        else begin
            e = sbq.pop_front();
            checks++; if (obs_ack !== e.ack || obs_c !== e.lat) begin errors++; $display("FAIL bg_ack got=%b@%0d want=%b@%0d", obs_ack, obs_c, e.ack, e.lat); end
            checks++; if (obs_rd !== e.rd) begin errors++; $display("FAIL bg_rdata got=%h want=%h", obs_rd, e.rd); end
        end
    endtask

    task automatic test_back_to_back_arb();
        exp_t e;
        int n1, n2, reps;
        logic [NCH-1:0] prev;
        logic [NCH-1:0] order [5];
        n1 = 0; n2 = 0; reps = 0; prev = '0;
        order[0] = 4'b0001; order[1] = 4'b0010; order[2] = 4'b0100; order[3] = 4'b1000; order[4] = 4'b0001;
        @(posedge clk); #1 PPclr = 1'b1;
        @(posedge clk); #1 PPclr = 1'b0;
        rdata_model = 16'h1357;
        ED_in = 16'h1357;
        we = '0;
        wait_cfg = '0;
        for (int i = 0; i < 5; i++) sbq.push_back('{ack: order[i], err: 4'b0, rd: rdata_model, lat: 0});
        req = 4'hF;
        for (int c = 0; c < 60 && (n1 < 5 || n2 < 5); c++) begin
            @(negedge clk);
            if (|ack && sbq.size() > 0) begin
                e = sbq.pop_front();
                n1++;
                if (ack == prev) reps++;
                prev = ack;
                checks++; if (ack !== e.ack) begin errors++; $display("FAIL rr_grant%0d got=%b want=%b", n1, ack, e.ack); end
                checks++; if (rdata !== e.rd) begin errors++; $display("FAIL rr_rdata%0d got=%h want=%h", n1, rdata, e.rd); end
            end
            if (|ack2) begin
                n2++;
                checks++; if (ack2 !== 4'b0001) begin errors++; $display("FAIL fix_grant%0d got=%b want=0001", n2, ack2); end
            end
            if (n1 >= 5 && n2 >= 5) req = '0;
        end
        req = '0;
        checks++; if (n1 !== 5 || n2 !== 5) begin errors++; $display("FAIL arb_count got=%0d/%0d want=5/5", n1, n2); end
        checks++; if (reps !== 0) begin errors++; $display("FAIL rr_repeat got=%0d want=0", reps); end
        repeat (3) @(negedge clk);
    endtask

    task automatic test_abort();
        int late;
        late = 0;
        XRDY = 1'b0;
        issue(0, 1'b0, 15'h7FFF, 16'h0, 6'd3, '{ack: 4'b0001, err: 4'b0, rd: rdata_model, lat: 0});
        @(posedge clk);
        repeat (7) @(negedge clk);
        checks++; if ({busy, RDn, CSn} !== 6'b1_0_1110) begin errors++; $display("FAIL ab_in_xwait got=%b want=101110", {busy, RDn, CSn}); end
        #2 PPclr = 1'b1;
        #1;
        checks++; if ({CSn, RDn, WRn} !== 6'h3F) begin errors++; $display("FAIL ab_strobes got=%h want=3f", {CSn, RDn, WRn}); end
        checks++; if ({EA_oe, ED_oe, busy, ack, err} !== 11'h0) begin errors++; $display("FAIL ab_ctrl got=%h want=0", {EA_oe, ED_oe, busy, ack, err}); end
        checks++; if ({EA_do, ED_do, rdata} !== 47'h0) begin errors++; $display("FAIL ab_data got=%h want=0", {EA_do, ED_do, rdata}); end
        req = '0;
        XRDY = 1'b1;
        if (sbq.size() > 0) void'(sbq.pop_front());
        @(posedge clk); #1 PPclr = 1'b0;
        repeat (20) begin
            @(negedge clk);
            if (|ack || |err) late++;
        end
        checks++; if (late !== 0) begin errors++; $display("FAIL ab_no_pulse got=%0d want=0", late); end
        checks++; if (sbq.size() !== 0) begin errors++; $display("FAIL sb_leftover got=%0d want=0", sbq.size()); end
    endtask

    initial begin
        PPclr = 1'b1; req = '0; we = '0; addr = '0; wdata = '0; wait_cfg = '0;
        BGn = 1'b1; XRDY = 1'b1; ED_in = '0; rdata_model = '0;
        test_reset();
        test_read();
        test_write();
        test_timeout();
        test_bus_grant();
        test_back_to_back_arb();
        test_abort();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/emc_mch.md
# emc_mch

Parametrised multi-channel external memory controller for the DSP core. It arbitrates among `NCH` internal requesters (PM, DM, IO, boot/DMA, …) for the single external address/data bus. Per access it drives chip-select, RDn/WRn and address/data pins with a per-channel programmable wait-state count, then extends the strobe on an external ready pin with a timeout. It sits between the core's memory-interface logic and the pad ring, and replaces the fixed three-space controller.

## Interface
- `NCH`, 4: number of requesting channels (1..8).
- `AW`, 15: external address width.
- `DW`, 16: external data width.
- `WW`, 6: wait-state field width per channel.
- `ARB`, 1: 0 = fixed priority (ch0 highest), 1 = round-robin.
- `TMO`, 64: ready-timeout limit in cycles (≥2).

Ports:
- `DSPCLK` input 1: clock, rising edge.
- `PPclr` input 1: reset, asynchronous, active-high.
- `req` input NCH: per-channel access request; held until `ack` or `err` for that channel.
- `we` input NCH: 1 = write, 0 = read; stable while `req` is high.
- `addr` input NCH*AW: channel addresses, packed, ch0 in LSBs.
- `wdata` input NCH*DW: channel write data, packed.
- `wait_cfg` input NCH*WW: wait states per channel, packed.
- `BGn` input 1: bus grant, active-low; low blocks new accesses.
- `XRDY` input 1: external ready, high = ready.
- `ED_in` input DW: external data bus input.
- `ack` output NCH: one-cycle completion pulse to the served channel.
- `err` output NCH: one-cycle timeout pulse to the served channel.
- `rdata` output DW: read data, valid in the `ack` cycle and held until the next read completes.
- `CSn` output NCH: per-channel chip select, active-low.
- `RDn` output 1: read strobe.
- `WRn` output 1: write strobe.
- `EA_do` output AW: external address.
- `EA_oe` output 1: address enable.
- `ED_do` output DW: external write data.
- `ED_oe` output 1: data enable.
- `busy` output 1: an access is in progress.

## Operation
- FSM states: IDLE, STRB, XWAIT, END.
- IDLE:
  - If `BGn`=0 or no `req`, stay in IDLE.
  - Otherwise the arbiter picks channel `g`. Latch `g`, `we[g]`, `addr[g]`, `wdata[g]` and `wait_cfg[g]`. Clear the wait counter `cnt`. Go to STRB.
- STRB:
  - `CSn[g]`=0, `EA_oe`=1, `EA_do`=latched address.
  - The active strobe (`RDn` or `WRn`) is 0. For writes, `ED_oe`=1 and `ED_do`=latched data.
  - `cnt` increments each cycle. When `cnt`==wait value: if `XRDY`=1, go to END; otherwise go to XWAIT and clear the timeout counter `tcnt`.
- XWAIT:
  - Strobes stay asserted; `tcnt` increments.
  - If `XRDY`=1, go to END.
  - If `tcnt`==`TMO`-1, go to END with the timeout flag set.
- END:
  - Strobes are high; `CSn[g]`, `EA_oe` and the write `ED_oe` are held (hold cycle).
  - On a read without timeout, `rdata` captures `ED_in` on the STRB/XWAIT→END edge.
  - Pulse `ack[g]`, or `err[g]` if timed out. A timed-out read leaves `rdata` unchanged.
  - Next cycle: IDLE.
- Round-robin arbitration:
  - The pointer advances to `g`+1 (mod `NCH`) after each grant.
  - The search starts at the pointer. A channel that has just been served loses to any other pending channel.
- `BGn` is sampled only in IDLE. An in-flight access always completes; the bus is never released mid-strobe.
- Wait value 0 gives a single STRB cycle. The wait counter is `WW` bits and never wraps (it compares for equality before incrementing).
- Reset values (asynchronous on `PPclr`):
  - state IDLE; `CSn`, `RDn`, `WRn` all 1.
  - `EA_oe`, `ED_oe`, `ack`, `err`, `busy` all 0.
  - `EA_do`, `ED_do`, `rdata` all 0; `cnt`, `tcnt`, arbiter pointer all 0.
- `PPclr` mid-access aborts immediately with no `ack`/`err`. The requester re-issues after reset.

## Timing
- All pin outputs, `ack`, `err` and `busy` are registered; there are no combinational input→pin paths.
- Let `req` be sampled at edge k with `XRDY`=1:
  - STRB occupies cycles k+1..k+1+W.
  - END occupies cycle k+2+W, in which `ack` is high.
  - Latency from `req` to `ack` is W+2 cycles.
- Each cycle of `XRDY`=0 after wait expiry adds one cycle.
- Back-to-back accesses: the earliest next STRB is 2 cycles after END (IDLE takes one cycle). The requester drops `req` in the `ack` cycle. A `req` still high in the cycle after `ack` is treated as a new request.
- `busy` = state≠IDLE, as a registered copy.

## Structure
- Package `emc_mch_pkg`: state enum, TMO counter width `$clog2(TMO)`, and a pack/unpack helper for channel fields.
- Sub-module `emc_rr_arb` (NCH, ARB): inputs `req`, `adv`; outputs one-hot `gnt` and `valid`. It holds the round-robin pointer.
- The top level contains the FSM, the counters and the output registers.

## Test plan
- NCH=4, ch1 read, wait=3, `XRDY`=1, `ED_in`=16'hA5C3 → `CSn`=4'b1101, `RDn` low for 4 cycles, `ack`=4'b0010 at k+5, `rdata`=16'hA5C3.
- ch2 write addr 15'h1234, data 16'hBEEF, wait=0 → `WRn` low for 1 cycle, `ED_oe`=1 from STRB through END, `EA_do`=15'h1234, `ack[2]` at k+2.
- ARB=1, all four `req` held, wait=0 → grants in order 0,1,2,3,0 with no channel served twice in a row. Repeat with ARB=0 → ch0 is served every time.
- TMO=8, `XRDY` held 0, wait=2 → `err[g]` pulse at k+2+2+8, no `ack`, `rdata` unchanged.
- `BGn`=0 with `req[0]`=1 → stays IDLE and all `oe`=0. Then `BGn` goes low during STRB → the access still completes with `ack`.
- `PPclr` pulse in XWAIT → all outputs return to their reset values asynchronously, and there is no `ack`/`err` afterwards.
